lsu_mem_interface: RTL and testbench
====================================

# lsu_mem_interface

Load/store unit for the RISC-V core: accepts one memory request at a time from the execute stage and runs it over a single-outstanding valid/ready data-memory bus. Its jobs are:
- byte-lane alignment, byte enables and write-data replication;
- load-result extraction and sign/zero extension;
- misalignment and bus-timeout errors.

The extended load result drives the memory-data input of the writeback 4:1 result multiplexer.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles to wait for `mem_ready` before aborting. Legal range 1..255.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  execute stage presents a request.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `mem_valid`  out  1  bus request active.
- `mem_we`  out  1  bus write strobe.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  32  word address, `{req_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  bus completes the transfer this cycle; read data valid in the same cycle.
- `mem_rdata`  in  32  read data word.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_error`  out  1  qualifies `rsp_valid`: misaligned, reserved size, or timeout.
- `load_data`  out  32  extended load result; holds until the next response.

## Operation
State machine: IDLE, BUS, RESP.

IDLE
- `req_ready`=1.
- On `req_valid`, the request is accepted and all fields are registered.
- Error check on the accepted request: size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Error: go to RESP with error flag set. No bus transaction is issued.
  - Otherwise: go to BUS.

BUS
- `mem_valid`=1; `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` come from registers and are stable for the whole state.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << addr[1:0]`
  - word: `4'b1111`
- Store data replication:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- A wait counter clears on entry and increments each cycle with `mem_ready`=0.
- On `mem_ready`=1, go to RESP.
  - Load: capture `mem_rdata >> (8*addr[1:0])`, then extend bit 7 (byte) or bit 15 (half) unless `req_unsigned`. Word is taken unchanged.
  - Store: `load_data` is unchanged.
- If the counter reaches `TIMEOUT_CYCLES` with `mem_ready` still low, drop `mem_valid` and go to RESP with error set.
- `mem_ready` in the cycle the counter hits the limit takes priority: the transfer completes normally.

RESP
- `rsp_valid`=1 for exactly one cycle, `rsp_error` per flag.
- On any error, `load_data` is forced to 0.
- Next state is always IDLE.
- `req_valid` is ignored in RESP and BUS (`req_ready`=0).

Other rules:
- `mem_ready` outside BUS is ignored.
- `req_unsigned` is ignored for stores and for word loads.

## Timing
- Reset (asynchronous, immediate): state IDLE; `req_ready`=1; all other outputs 0, including `mem_valid`, `mem_be`, `mem_addr`, `mem_wdata`, `rsp_valid`, `rsp_error`, `load_data`; counter 0.
- Reset in BUS aborts the transfer. `mem_valid` falls asynchronously and no response is produced.
- Accept at edge N. `mem_valid` is high from cycle N+1.
- `mem_ready` in cycle N+k (k≥1) gives `rsp_valid` in cycle N+k+1. Minimum latency is 2 cycles; throughput is at most one request per 3 cycles.
- Misaligned or reserved request accepted at edge N gives `rsp_valid`+`rsp_error` in cycle N+1. `mem_valid` never rises.
- Timeout: `mem_valid` is high for exactly `TIMEOUT_CYCLES` cycles, then `rsp_error` the next cycle.
- `load_data` updates on the edge entering RESP and is stable until the next response.

## Test plan
- Reset then idle: `rst_n`=0 asserted mid-cycle → all outputs 0 and `req_ready`=1 immediately. With `req_valid`=0 for 10 cycles → `mem_valid` stays 0.
- Signed/unsigned byte load:
  - addr 0x1003, size 00, signed, `mem_rdata`=0x80FF_0000, `mem_ready` on first BUS cycle → `mem_addr`=0x1000, `mem_be`=1000, `rsp_valid` 2 cycles after accept, `load_data`=0xFFFF_FF80.
  - Same with `req_unsigned`=1 → 0x0000_0080.
- Half store with wait states: addr 0x2002, size 01, wdata 0xDEAD_BEEF, `mem_ready` after 3 wait cycles → `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF held 4 cycles, `rsp_valid` with `rsp_error`=0, `load_data` unchanged.
- Misaligned: word load at 0x3001 → no `mem_valid`, `rsp_valid`=`rsp_error`=1 one cycle after accept, `load_data`=0. Repeat with size 11 at 0x3000 → same response.
- Timeout: `TIMEOUT_CYCLES`=4, `mem_ready` held 0 → `mem_valid` high for exactly 4 cycles, then `rsp_error`. Separately, `mem_ready` in the 4th cycle → normal completion, no error.
- Back-to-back and abort: `req_valid` held high across 3 word loads → accepts only in IDLE, spacing 3 cycles. Reset asserted during BUS → `mem_valid` drops at once, no `rsp_valid` after reset release.

Source files
------------

// File: rtl/lsu_mem_interface.sv
// Load/store unit bridging the execute stage to a single-outstanding
// valid/ready data-memory bus. Handles byte-lane alignment, byte enables,
// store-data replication, load extension, misalignment and bus timeout.
module lsu_mem_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [31:0] load_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Last wait-counter value before the transfer is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] load_q, load_d;

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] res;
    res = 32'h0000_0000;
    case (size)
      2'b00:   res = {4{wd[7:0]}};
      2'b01:   res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Reserved size, odd half address or non-word-aligned word address.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] extend_load(input logic [1:0] size, input logic uns,
                                              input logic [31:0] rd, input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = rd >> {off, 3'b000};
    res = sh;
    case (size)
      2'b00:   res = uns ? {24'h00_0000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Next-state and datapath capture for the IDLE/BUS/RESP sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    load_d  = load_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          be_d    = calc_be(req_size, req_addr[1:0]);
          wdata_d = calc_wdata(req_size, req_wdata);
          cnt_d   = 8'd0;
          err_d   = is_bad_req(req_size, req_addr[1:0]);
          if (is_bad_req(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            load_d  = 32'h0000_0000;
          end else begin
            state_d = ST_BUS;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        // A ready in the final allowed cycle still completes normally.
        if (mem_ready) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          if (!we_q) begin
            load_d = extend_load(size_q, uns_q, mem_rdata, addr_q[1:0]);
          end else begin
            load_d = load_q;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          load_d  = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
      load_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_valid = (state_q == ST_BUS);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_error = (state_q == ST_RESP) & err_q;
  assign load_data = load_q;

endmodule

// File: tb/tb_lsu_mem_interface.sv
// Directed bench for lsu_mem_interface with TIMEOUT_CYCLES = 4.
module tb_lsu_mem_interface;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        mem_valid;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] load_data;

  int total;
  int bad;

  lsu_mem_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    step();
    req_valid    = 1'b0;
  endtask

  // Hold BUS for 'waits' not-ready cycles, then complete; checks bus fields each cycle.
  task automatic bus_xfer(input int waits, input logic [31:0] rdata, input logic we,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wdata);
    for (int i = 0; i <= waits; i++) begin
      check_eq("mem_valid", {31'd0, mem_valid}, 32'd1);
      check_eq("mem_addr", mem_addr, e_addr);
      check_eq("mem_be", {28'd0, mem_be}, {28'd0, e_be});
      check_eq("mem_we", {31'd0, mem_we}, {31'd0, we});
      if (we) check_eq("mem_wdata", mem_wdata, e_wdata);
      mem_ready = (i == waits);
      mem_rdata = rdata;
      step();
    end
    mem_ready = 1'b0;
  endtask

  // Check the single RESP cycle and the return to IDLE.
  task automatic check_resp(input string tag, input logic err, input logic [31:0] e_load);
    check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_eq({tag, "_rsp_error"}, {31'd0, rsp_error}, {31'd0, err});
    check_eq({tag, "_load"}, load_data, e_load);
    check_eq({tag, "_mvalid_resp"}, {31'd0, mem_valid}, 32'd0);
    step();
    check_eq({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
    check_eq({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    check_eq({tag, "_load_hold"}, load_data, e_load);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [8:0] rdy_pat;
    logic [8:0] rsp_pat;
    total = 0;
    bad = 0;
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;

    // Asynchronous reset mid-cycle
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check_eq("rst_load", load_data, 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_mem_valid", {31'd0, mem_valid}, 32'd0);
    end

    // Signed byte load at top lane
    issue(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    bus_xfer(0, 32'h80FF_0000, 1'b0, 32'h0000_1000, 4'b1000, 32'h0);
    check_resp("lb", 1'b0, 32'hFFFF_FF80);

    // Unsigned byte load
    issue(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    bus_xfer(0, 32'h80FF_0000, 1'b0, 32'h0000_1000, 4'b1000, 32'h0);
    check_resp("lbu", 1'b0, 32'h0000_0080);

    // Timeout: mem_valid for exactly 4 cycles then error
    issue(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      check_eq("to_mem_valid", {31'd0, mem_valid}, 32'd1);
      step();
    end
    check_resp("timeout", 1'b1, 32'h0000_0000);

    // Ready in the last allowed cycle completes normally
    issue(1'b0, 2'b10, 1'b1, 32'h0000_5000, 32'h0);
    bus_xfer(3, 32'h1234_5678, 1'b0, 32'h0000_5000, 4'b1111, 32'h0);
    check_resp("lw_late", 1'b0, 32'h1234_5678);

    // Signed half load, upper lane
    issue(1'b0, 2'b01, 1'b0, 32'h0000_6002, 32'h0);
    bus_xfer(1, 32'hF00D_1234, 1'b0, 32'h0000_6000, 4'b1100, 32'h0);
    check_resp("lh", 1'b0, 32'hFFFF_F00D);

    // Half store with 3 wait cycles; load_data untouched
    issue(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF);
    bus_xfer(3, 32'h5555_5555, 1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF);
    check_resp("sh", 1'b0, 32'hFFFF_F00D);

    // Byte store at lane 1
    issue(1'b1, 2'b00, 1'b0, 32'h0000_2101, 32'h0000_00A5);
    bus_xfer(0, 32'h0, 1'b1, 32'h0000_2100, 4'b0010, 32'hA5A5_A5A5);
    check_resp("sb", 1'b0, 32'hFFFF_F00D);

    // Reserved size: immediate error, no bus
    issue(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0);
    check_resp("rsvd", 1'b1, 32'h0000_0000);

    // Misaligned word
    issue(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
    check_resp("misal", 1'b1, 32'h0000_0000);

    // Misaligned half
    issue(1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'h0);
    check_resp("misal_h", 1'b1, 32'h0000_0000);

    // Back-to-back word loads with req_valid and mem_ready held high
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_7000;
    rdy_pat = 9'd0;
    rsp_pat = 9'd0;
    for (int i = 8; i >= 0; i--) begin
      step();
      rdy_pat[i] = req_ready;
      rsp_pat[i] = rsp_valid;
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    check_eq("b2b_ready_pat", {23'd0, rdy_pat}, {23'd0, 9'b001001001});
    check_eq("b2b_rsp_pat", {23'd0, rsp_pat}, {23'd0, 9'b010010010});
    check_eq("b2b_load", load_data, 32'hCAFE_F00D);

    // Reset during BUS aborts the transfer
    step();
    issue(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0);
    check_eq("abort_in_bus", {31'd0, mem_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    check_eq("abort_load", load_data, 32'd0);
    #2 rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
      check_eq("abort_no_bus", {31'd0, mem_valid}, 32'd0);
    end
    mem_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
